apb_uart_tx_serializer: RTL and testbench
=========================================

Name: apb_uart_tx_serializer

Overview:
UART transmit serializer that sits directly downstream of the TX FIFO in the APB UART.
- Pops one character per frame from the FIFO output through a valid/ready handshake.
- Drives the serial TX line with start bit, 5-8 data bits (LSB first), optional parity and 1 or 2 stop bits.
- Bit timing comes from an internal per-bit clock-divider counter. The divisor is supplied by the APB register block.

Parameters:
DATA_WIDTH, 8, width of tx_data_i; frame data bits are cfg_bits_i-selected, max 8.
DIV_WIDTH, 16, width of the baud divisor input.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
cfg_en_i  input  1  transmitter enable; gates acceptance of new frames only
cfg_div_i  input  DIV_WIDTH  clocks per bit minus 1 (bit period = cfg_div_i+1 clocks)
cfg_bits_i  input  2  data bits: 00=5, 01=6, 10=7, 11=8
cfg_parity_en_i  input  1  1 = append parity bit
cfg_parity_odd_i  input  1  1 = odd parity, 0 = even parity
cfg_stop2_i  input  1  1 = two stop bits, 0 = one
tx_valid_i  input  1  FIFO has data (connects to FIFO valid_o)
tx_data_i  input  DATA_WIDTH  character to send (FIFO data_o)
tx_ready_o  output  1  pop strobe to FIFO (connects to FIFO ready_i)
tx_o  output  1  serial line, idle high
busy_o  output  1  frame in progress
done_o  output  1  one-cycle pulse at frame completion

Behaviour:
- Reset is asynchronous and active-low (reset_n), clocked on clk.
- Reset values: state=IDLE, tx_o=1, busy_o=0, done_o=0, baud counter=0, bit counter=0, shift register=0.
- tx_ready_o is combinational: (state==IDLE) & cfg_en_i. It may be high out of reset when cfg_en_i=1.
- Handshake: a transfer occurs on a rising edge where tx_valid_i & tx_ready_o.
  - That edge latches tx_data_i plus all cfg_* fields into frame registers.
  - Latched values hold for the whole frame; cfg changes mid-frame have no effect.
- States: IDLE -> START -> DATA -> (PARITY if parity enabled) -> STOP -> IDLE.
- Output levels per state:
  - IDLE: tx_o=1.
  - START: tx_o=0, entered on the handshake edge, so tx_o falls in the cycle after the handshake (latency 1).
  - DATA: tx_o = shift[0]; shift right at each bit end; bit counter runs 0..N-1 (N=5..8).
  - PARITY: tx_o = XOR of the N used data bits, inverted when odd. Bits above N-1 are ignored for both data and parity.
  - STOP: tx_o=1 for 1 or 2 bit periods.
- Baud counter:
  - Reloads to 0 on every state/bit boundary.
  - A bit ends when counter==div_latched. Every bit lasts exactly div_latched+1 clocks.
  - div=0 gives 1-clock bits.
- Frame length is (div+1)*(1+N+P+S) clocks, where P=0/1 (parity) and S=1/2 (stop bits).
- At the end of the last stop bit: go to IDLE. In that first IDLE cycle done_o=1 (registered, exactly one cycle) and tx_ready_o=cfg_en_i.
- Back-to-back: if tx_valid_i is high in that first IDLE cycle, the next handshake happens there. The line stays high between frames for exactly 1 clock.
- busy_o=1 in START, DATA, PARITY and STOP; 0 in IDLE.
- cfg_en_i dropped mid-frame: the current frame completes normally, done_o pulses, and no new frame is accepted.
- tx_valid_i low in IDLE: stay in IDLE with tx_o=1 and no pop.
- reset_n asserted mid-frame: immediate return to reset values; tx_o=1 asynchronously. The partial character is lost and is not re-fetched.

Test Plan:
- Reset with cfg_en_i=1, tx_valid_i=0 -> tx_o=1, busy_o=0, done_o=0, tx_ready_o=1.
- div=3, 8N1, data 0xA5:
  - Handshake at cycle 0; tx_o=0 for cycles 1-4.
  - Data bits 1,0,1,0,0,1,0,1 for 4 clocks each, then stop=1 for 4 clocks.
  - done_o high at cycle 41; exactly 1 pop.
- div=1, 7 bits, even parity, data 0x83 (7 bits = 0x03) -> parity bit 0; with odd parity -> 1. Bit 7 must not appear on the line; frame = 2*10 clocks.
- div=0, 5 bits, no parity, 2 stop bits, FIFO holding 0x1F,0x00 -> two frames of 8 clocks each.
  - Exactly 1 idle-high cycle between frames.
  - tx_ready_o pulses exactly twice.
  - Frame 2 data bits all 0.
- Change cfg_div_i 3->7 and clear cfg_en_i mid-frame -> current frame keeps 4-clock bits and completes with a done_o pulse; tx_ready_o stays 0 afterward while tx_valid_i=1.
- Assert reset_n low during DATA bit 3 -> tx_o=1 the same cycle, state IDLE; after release with cfg_en_i=1 the next FIFO entry is sent cleanly.

Source files
------------

// File: rtl/apb_uart_tx_serializer.sv
// apb_uart_tx_serializer: pops characters from the TX FIFO and shifts them out as
// UART frames (start, 5-8 data bits LSB first, optional parity, 1-2 stop bits).
module apb_uart_tx_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cfg_en_i,
  input  logic [DIV_WIDTH-1:0]  cfg_div_i,
  input  logic [1:0]            cfg_bits_i,
  input  logic                  cfg_parity_en_i,
  input  logic                  cfg_parity_odd_i,
  input  logic                  cfg_stop2_i,
  input  logic                  tx_valid_i,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  output logic                  tx_ready_o,
  output logic                  tx_o,
  output logic                  busy_o,
  output logic                  done_o
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t                state, state_n;
  logic [DIV_WIDTH-1:0]  cnt, cnt_n, div_l, div_n;
  logic [2:0]            bit_cnt, bit_n;
  logic [DATA_WIDTH-1:0] shift, shift_n;
  logic [1:0]            bits_l, bits_n;
  logic                  par_en_l, par_en_n, par_l, par_n, stop2_l, stop2_n;
  logic                  done_n, par_calc, bit_end, take;

  assign tx_ready_o = (state == IDLE) & cfg_en_i;
  assign take       = tx_ready_o & tx_valid_i;
  assign bit_end    = cnt == div_l;
  assign busy_o     = state != IDLE;
  assign tx_o       = state == START ? 1'b0 : state == DATA ? shift[0] : state == PARITY ? par_l : 1'b1;

  // Parity is computed once at the handshake over only the configured data bits.
  always_comb begin
    par_calc = cfg_parity_odd_i;
    for (int i = 0; i < 8; i++)
      if (i <= 4 + int'(cfg_bits_i)) par_calc = par_calc ^ tx_data_i[i];
  end

  always_comb begin
    state_n  = state;
    cnt_n    = (state == IDLE || bit_end) ? '0 : cnt + 1'b1;
    bit_n    = bit_cnt;
    shift_n  = shift;
    div_n    = div_l;
    bits_n   = bits_l;
    par_en_n = par_en_l;
    par_n    = par_l;
    stop2_n  = stop2_l;
    done_n   = 1'b0;
    case (state)
      IDLE: if (take) begin
        state_n  = START;
        shift_n  = tx_data_i;
        div_n    = cfg_div_i;
        bits_n   = cfg_bits_i;
        par_en_n = cfg_parity_en_i;
        par_n    = par_calc;
        stop2_n  = cfg_stop2_i;
        bit_n    = '0;
      end
      START: if (bit_end) state_n = DATA;
      DATA: if (bit_end) begin
        shift_n = shift >> 1;
        if (bit_cnt == {1'b1, bits_l}) begin
          state_n = par_en_l ? PARITY : STOP;
          bit_n   = '0;
        end else bit_n = bit_cnt + 1'b1;
      end
      PARITY: if (bit_end) state_n = STOP;
      STOP: if (bit_end) begin
        if (bit_cnt == {2'b00, stop2_l}) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else bit_n = bit_cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      div_l    <= '0;
      bits_l   <= '0;
      par_en_l <= 1'b0;
      par_l    <= 1'b0;
      stop2_l  <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_cnt  <= bit_n;
      shift    <= shift_n;
      div_l    <= div_n;
      bits_l   <= bits_n;
      par_en_l <= par_en_n;
      par_l    <= par_n;
      stop2_l  <= stop2_n;
      done_o   <= done_n;
    end
  end
endmodule

// File: tb/tb_apb_uart_tx_serializer.sv
// tb_apb_uart_tx_serializer: directed frames against hand-built line patterns,
// fed from a small FIFO model that counts pops.
module tb_apb_uart_tx_serializer;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic        cfg_en = 1'b1, cfg_parity_en = 1'b0, cfg_parity_odd = 1'b0, cfg_stop2 = 1'b0;
  logic [15:0] cfg_div = 16'd3;
  logic [1:0]  cfg_bits = 2'b11;
  logic        tx_valid, tx_ready, tx_line, busy, done;
  logic [7:0]  tx_data;
  logic [7:0]  mem [8];
  logic [3:0]  wr = '0, rd = '0;
  int          pops = 0, pops0;
  int          errors = 0, checks = 0;

  apb_uart_tx_serializer dut (
    .clk(clk), .reset_n(reset_n), .cfg_en_i(cfg_en), .cfg_div_i(cfg_div),
    .cfg_bits_i(cfg_bits), .cfg_parity_en_i(cfg_parity_en), .cfg_parity_odd_i(cfg_parity_odd),
    .cfg_stop2_i(cfg_stop2), .tx_valid_i(tx_valid), .tx_data_i(tx_data),
    .tx_ready_o(tx_ready), .tx_o(tx_line), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  assign tx_valid = rd != wr;
  assign tx_data  = mem[rd[2:0]];

  always @(posedge clk) if (reset_n && tx_valid && tx_ready) begin
    rd   <= rd + 1'b1;
    pops <= pops + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr[2:0]] = d;
    wr = wr + 1'b1;
  endtask

  // Expects the handshake on the coming edge; bits[0] is the first bit on the line.
  // Returns at the negedge of the first idle cycle, after checking done_o there.
  task automatic check_frame(input string tag, input logic [15:0] bits, input int n, input int div);
    for (int b = 0; b < n; b++)
      for (int c = 0; c <= div; c++) begin
        @(negedge clk);
        check($sformatf("%s bit%0d clk%0d tx", tag, b, c), 32'(tx_line), 32'(bits[b]));
        check($sformatf("%s bit%0d busy", tag, b), 32'(busy), 32'd1);
      end
    @(negedge clk);
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " idle busy"}, 32'(busy), 32'd0);
    check({tag, " idle tx"}, 32'(tx_line), 32'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst tx", 32'(tx_line), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst ready", 32'(tx_ready), 32'd1);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle no valid tx", 32'(tx_line), 32'd1);
    check("idle no pop", 32'(pops), 32'd0);

    push(8'hA5);
    check_frame("8N1 A5", {1'b1, 8'hA5, 1'b0}, 10, 3);
    check("8N1 pops", 32'(pops), 32'd1);
    @(negedge clk);
    check("8N1 done one cycle", 32'(done), 32'd0);

    cfg_div = 16'd1; cfg_bits = 2'b10; cfg_parity_en = 1'b1; cfg_parity_odd = 1'b0;
    push(8'h83);
    check_frame("7E1 83", {1'b1, 1'b0, 7'h03, 1'b0}, 10, 1);
    cfg_parity_odd = 1'b1;
    push(8'h83);
    check_frame("7O1 83", {1'b1, 1'b1, 7'h03, 1'b0}, 10, 1);

    @(negedge clk);
    pops0 = pops;
    cfg_div = 16'd0; cfg_bits = 2'b00; cfg_parity_en = 1'b0; cfg_stop2 = 1'b1;
    push(8'h1F);
    push(8'h00);
    check_frame("5N2 1F", {2'b11, 5'h1F, 1'b0}, 8, 0);
    check_frame("5N2 00", {2'b11, 5'h00, 1'b0}, 8, 0);
    check("5N2 pops", 32'(pops - pops0), 32'd2);

    @(negedge clk);
    pops0 = pops;
    cfg_div = 16'd3; cfg_bits = 2'b11; cfg_stop2 = 1'b0;
    push(8'h3C);
    push(8'h55);
    fork
      check_frame("midcfg 3C", {1'b1, 8'h3C, 1'b0}, 10, 3);
      begin
        repeat (6) @(negedge clk);
        cfg_div = 16'd7;
        cfg_en  = 1'b0;
      end
    join
    check("midcfg ready at done", 32'(tx_ready), 32'd0);
    repeat (4) begin
      @(negedge clk);
      check("disabled ready", 32'(tx_ready), 32'd0);
      check("disabled tx", 32'(tx_line), 32'd1);
    end
    check("disabled pops", 32'(pops - pops0), 32'd1);
    cfg_en = 1'b1; cfg_div = 16'd0;
    check_frame("reenable 55", {1'b1, 8'h55, 1'b0}, 10, 0);

    pops0 = pops;
    cfg_div = 16'd3;
    push(8'h00);
    push(8'h96);
    repeat (18) @(negedge clk);
    check("pre-reset data bit3", 32'(tx_line), 32'd0);
    check("pre-reset busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("async reset tx", 32'(tx_line), 32'd1);
    check("async reset busy", 32'(busy), 32'd0);
    check("async reset ready", 32'(tx_ready), 32'd1);
    @(negedge clk);
    check("held reset no pop", 32'(pops - pops0), 32'd1);
    reset_n = 1'b1;
    check_frame("after reset 96", {1'b1, 8'h96, 1'b0}, 10, 3);
    check("after reset pops", 32'(pops - pops0), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
